// File: rtl/mips_mem_responder_if.sv
// Word request/response bus between the multicycle MIPS core and memory.
// The core drives the request side, the responder answers with ready/err.
interface mips_mem_responder_if;
    logic        req;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic        memwrite;
    logic [31:0] readdata;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output req, adr, writedata, memwrite,
        input  readdata, ready, err, busy
    );

    modport slave (
        input  req, adr, writedata, memwrite,
        output readdata, ready, err, busy
    );
endinterface

// File: rtl/mips_mem_responder.sv
// Fixed-latency memory responder for the multicycle MIPS unified bus.
// One request in flight; ready pulses LATENCY cycles after acceptance.
module mips_mem_responder #(
    parameter int AW      = 6,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wd_q, wd_d;
    logic          we_q, we_d;
    logic          bad_q, bad_d;
    logic [31:0]   rd_q, rd_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic [31:0]   mem [2**AW];

    // Next-state and response computation; the response lands on the RESP exit edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        we_d    = we_q;
        bad_d   = bad_q;
        rd_d    = rd_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    idx_d = bus.adr[AW+1:2];
                    wd_d  = bus.writedata;
                    we_d  = bus.memwrite;
                    bad_d = (bus.adr[1:0] != 2'b00) ||
                            ((bus.adr >> (AW + 2)) != 32'd0);
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
                err_d   = bad_q;
                if (bad_q) begin
                    rd_d = 32'd0;
                end else if (!we_q) begin
                    rd_d = mem[idx_q];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // FSM and registered outputs; reset aborts any in-flight request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wd_q    <= 32'd0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            rd_q    <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Memory array store port; contents survive reset
    always_ff @(posedge clk) begin
        if (!reset && state_q == RESP && we_q && !bad_q) begin
            mem[idx_q] <= wd_q;
        end
    end

    assign bus.readdata = rd_q;
    assign bus.ready    = ready_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: directed table, multi-cycle corner cases,
// and random traffic against a word-array reference model.
module tb_mips_mem_responder;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   pa       = 0;
    int   pb       = 0;

    mips_mem_responder_if bus_a ();
    mips_mem_responder_if bus_b ();

    mips_mem_responder #(.AW(AW), .LATENCY(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    mips_mem_responder #(.AW(AW), .LATENCY(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_a.ready === 1'b1) pa <= pa + 1;
        if (bus_b.ready === 1'b1) pb <= pb + 1;
    end

    // reference model (dut_a only)
    logic [31:0] mdl_mem [2**AW];
    logic [31:0] mdl_rd;

    function automatic void model(input logic [31:0] a, input logic [31:0] wd,
                                  input logic we, output logic [31:0] erd,
                                  output logic eerr);
        logic bad;
        bad = (a % 4 != 0) || (a >= 4 * (2**AW));
        if (bad) begin
            mdl_rd = 32'd0;
        end else if (we) begin
            mdl_mem[a / 4] = wd;
        end else begin
            mdl_rd = mdl_mem[a / 4];
        end
        erd  = mdl_rd;
        eerr = bad;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int b, input logic r, input logic [31:0] a,
                         input logic [31:0] wd, input logic we);
        if (b == 0) begin
            bus_a.req = r; bus_a.adr = a;
            bus_a.writedata = wd; bus_a.memwrite = we;
        end else begin
            bus_b.req = r; bus_b.adr = a;
            bus_b.writedata = wd; bus_b.memwrite = we;
        end
    endtask

    function automatic logic [34:0] outs(input int b);
        if (b == 0) return {bus_a.ready, bus_a.err, bus_a.busy, bus_a.readdata};
        return {bus_b.ready, bus_b.err, bus_b.busy, bus_b.readdata};
    endfunction

    // one request, checking latency, busy, response data/err, pulse width
    task automatic xact(input int b, input logic [31:0] a, input logic [31:0] wd,
                        input logic we, input logic [31:0] erd, input logic eerr,
                        input string tag);
        logic [34:0] o;
        int lat;
        lat = 0;
        @(negedge clk);
        drive(b, 1'b1, a, wd, we);
        @(posedge clk);
        #1;
        drive(b, 1'b0, $urandom, $urandom, 1'b1);
        o = outs(b);
        check($sformatf("%s busy", tag), {31'd0, o[32]}, 32'd1);
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            o = outs(b);
            if (o[34]) lat = i;
        end
        check($sformatf("%s latency", tag), lat, (b == 0) ? 2 : 1);
        check($sformatf("%s readdata", tag), o[31:0], erd);
        check($sformatf("%s err", tag), {31'd0, o[33]}, {31'd0, eerr});
        @(posedge clk);
        #1;
        o = outs(b);
        check($sformatf("%s ready pulse", tag), {31'd0, o[34]}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mdl_rd = 32'd0;
    endtask

    // store to 0x20 then reset after `extra` extra edges (0: WAIT, 1: RESP)
    task automatic reset_mid(input int extra);
        int p0;
        @(negedge clk);
        drive(0, 1'b1, 32'h20, 32'h12345678, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (extra) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        p0 = pa;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mdl_rd = 32'd0;
        repeat (5) @(posedge clk);
        #1;
        check($sformatf("abort%0d pulses", extra), pa - p0, 0);
        check($sformatf("abort%0d busy", extra), {31'd0, bus_a.busy}, 32'd0);
        check($sformatf("abort%0d readdata", extra), bus_a.readdata, 32'd0);
    endtask

    typedef struct {
        logic [31:0] adr;
        logic [31:0] wd;
        logic        we;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [31:0] erd, a, wd;
        logic        eerr, we;
        logic [31:0] seq_adr [3];
        logic [31:0] seq_exp [3];
        int          last, p0, got;

        tbl[0] = '{32'h10,       32'hDEADBEEF, 1'b1, 32'h0,        1'b0};
        tbl[1] = '{32'h10,       32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
        tbl[2] = '{32'h13,       32'h0,        1'b0, 32'h0,        1'b1};
        tbl[3] = '{32'h0,        32'hA5A5A5A5, 1'b1, 32'h0,        1'b0};
        tbl[4] = '{32'h100,      32'hFFFFFFFF, 1'b1, 32'h0,        1'b1};
        tbl[5] = '{32'h0,        32'h0,        1'b0, 32'hA5A5A5A5, 1'b0};
        tbl[6] = '{32'hFC,       32'hCAFEF00D, 1'b1, 32'hA5A5A5A5, 1'b0};
        tbl[7] = '{32'hFC,       32'h0,        1'b0, 32'hCAFEF00D, 1'b0};
        tbl[8] = '{32'h80000000, 32'h0,        1'b0, 32'h0,        1'b1};
        tbl[9] = '{32'h20,       32'h0BADC0DE, 1'b1, 32'h0,        1'b0};

        reset = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 32'h0, 1'b0);
        do_reset();
        check("reset ready", {31'd0, bus_a.ready}, 32'd0);
        check("reset err", {31'd0, bus_a.err}, 32'd0);
        check("reset busy", {31'd0, bus_a.busy}, 32'd0);
        check("reset readdata", bus_a.readdata, 32'd0);

        for (int i = 0; i < 10; i++) begin
            model(tbl[i].adr, tbl[i].wd, tbl[i].we, erd, eerr);
            xact(0, tbl[i].adr, tbl[i].wd, tbl[i].we, tbl[i].rd, tbl[i].err,
                 $sformatf("vec%0d", i));
        end

        // req held high across three loads; garbage stores offered while busy
        seq_adr[0] = 32'h10; seq_exp[0] = 32'hDEADBEEF;
        seq_adr[1] = 32'h0;  seq_exp[1] = 32'hA5A5A5A5;
        seq_adr[2] = 32'hFC; seq_exp[2] = 32'hCAFEF00D;
        last = 0;
        p0 = pa;
        @(negedge clk);
        drive(0, 1'b1, seq_adr[0], 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            got = 0;
            for (int j = 0; j < 20 && got == 0; j++) begin
                @(posedge clk);
                #1;
                if (bus_a.ready) got = 1;
                else drive(0, 1'b1, $urandom, $urandom, 1'b1);
            end
            check($sformatf("b2b%0d seen", i), got, 1);
            check($sformatf("b2b%0d readdata", i), bus_a.readdata, seq_exp[i]);
            check($sformatf("b2b%0d err", i), {31'd0, bus_a.err}, 32'd0);
            if (i > 0) check($sformatf("b2b%0d spacing", i), cyc - last, 3);
            last = cyc;
            if (i < 2) drive(0, 1'b1, seq_adr[i+1], 32'h0, 1'b0);
            else drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        end
        repeat (6) @(posedge clk);
        #1;
        check("b2b pulse count", pa - p0, 3);
        mdl_rd = 32'hCAFEF00D;

        reset_mid(0);
        reset_mid(1);
        model(32'h20, 32'h0, 1'b0, erd, eerr);
        xact(0, 32'h20, 32'h0, 1'b0, 32'h0BADC0DE, 1'b0, "after abort");

        xact(1, 32'hFC, 32'h76543210, 1'b1, 32'h0, 1'b0, "lat1 store top");
        xact(1, 32'hFC, 32'h0, 1'b0, 32'h76543210, 1'b0, "lat1 load top");
        xact(1, 32'h100, 32'h0, 1'b0, 32'h0, 1'b1, "lat1 range");
        check("lat1 no stray pulses", pb, 3);

        for (int w = 0; w < 2**AW; w++) begin
            wd = $urandom;
            model(w * 4, wd, 1'b1, erd, eerr);
            xact(0, w * 4, wd, 1'b1, erd, eerr, $sformatf("init%0d", w));
        end

        for (int n = 0; n < 80; n++) begin
            case ($urandom % 8)
                0: a = {24'd0, 6'($urandom), 2'(1 + $urandom % 3)};
                1: a = 32'h100 + 32'($urandom % 1024) * 4;
                2: a = $urandom | 32'h80000000;
                default: a = {24'd0, 6'($urandom), 2'b00};
            endcase
            wd = $urandom;
            we = 1'($urandom);
            model(a, wd, we, erd, eerr);
            xact(0, a, wd, we, erd, eerr, $sformatf("rnd%0d a=%h we=%0d", n, a, we));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
